// File: rtl/data_memory_arbiter.sv
// Shared 32x8 data memory with a sequenced default-table initialisation and a
// round-robin CPU/debug arbiter using a registered grant/read-data handshake.
module data_memory_arbiter #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 32
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  soft_init,
    input  logic                  cpu_req,
    input  logic                  cpu_we,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic [DATA_WIDTH-1:0] cpu_wdata,
    output logic                  cpu_gnt,
    output logic                  cpu_rvalid,
    output logic [DATA_WIDTH-1:0] cpu_rdata,
    input  logic                  dbg_req,
    input  logic                  dbg_we,
    input  logic [ADDR_WIDTH-1:0] dbg_addr,
    input  logic [DATA_WIDTH-1:0] dbg_wdata,
    output logic                  dbg_gnt,
    output logic                  dbg_rvalid,
    output logic [DATA_WIDTH-1:0] dbg_rdata,
    output logic                  init_busy,
    output logic [7:0]            conflict_count
);

    typedef enum logic {ST_INIT, ST_RUN} state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   cnt_q, cnt_d;
    logic                    init_busy_q, init_busy_d;
    logic                    cpu_gnt_q, cpu_gnt_d, cpu_rvalid_q, cpu_rvalid_d;
    logic [DATA_WIDTH-1:0]   cpu_rdata_q, cpu_rdata_d;
    logic                    dbg_gnt_q, dbg_gnt_d, dbg_rvalid_q, dbg_rvalid_d;
    logic [DATA_WIDTH-1:0]   dbg_rdata_q, dbg_rdata_d;
    logic [7:0]              conflict_q, conflict_d;
    logic                    last_dbg_q, last_dbg_d;

    logic [DATA_WIDTH-1:0]   mem_q [DEPTH];
    logic                    mem_we;
    logic [ADDR_WIDTH-1:0]   mem_waddr;
    logic [DATA_WIDTH-1:0]   mem_wdata;
    logic                    cpu_elig, dbg_elig, cpu_win, dbg_win;

    // Lower half holds its own address; upper half counts down from zero (0, -1, -2, ...).
    function automatic logic [DATA_WIDTH-1:0] init_value(input logic [ADDR_WIDTH-1:0] a);
        logic [DATA_WIDTH-1:0] v;
        logic [DATA_WIDTH-1:0] half;
        v    = DATA_WIDTH'(a);
        half = DATA_WIDTH'(DEPTH / 2);
        if (v < half) return v;
        return half - v;
    endfunction

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        cpu_gnt_d    = 1'b0;
        cpu_rvalid_d = 1'b0;
        cpu_rdata_d  = cpu_rdata_q;
        dbg_gnt_d    = 1'b0;
        dbg_rvalid_d = 1'b0;
        dbg_rdata_d  = dbg_rdata_q;
        conflict_d   = conflict_q;
        last_dbg_d   = last_dbg_q;
        mem_we       = 1'b0;
        mem_waddr    = cnt_q;
        mem_wdata    = init_value(cnt_q);
        cpu_elig     = 1'b0;
        dbg_elig     = 1'b0;
        cpu_win      = 1'b0;
        dbg_win      = 1'b0;

        case (state_q)
            ST_INIT: begin
                mem_we = 1'b1;
                if (cnt_q == ADDR_WIDTH'(DEPTH - 1)) begin
                    cnt_d   = '0;
                    state_d = ST_RUN;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_RUN: begin
                if (soft_init) begin
                    state_d = ST_INIT;
                    cnt_d   = '0;
                end else begin
                    // A requester whose grant is showing this cycle is finishing, not asking again.
                    cpu_elig = cpu_req && !cpu_gnt_q;
                    dbg_elig = dbg_req && !dbg_gnt_q;
                    if (cpu_elig && dbg_elig) begin
                        cpu_win = last_dbg_q;
                        dbg_win = !last_dbg_q;
                        if (conflict_q != 8'hFF) conflict_d = conflict_q + 8'd1;
                    end else begin
                        cpu_win = cpu_elig;
                        dbg_win = dbg_elig;
                    end
                    if (cpu_win) begin
                        cpu_gnt_d    = 1'b1;
                        cpu_rvalid_d = !cpu_we;
                        last_dbg_d   = 1'b0;
                        if (cpu_we) begin
                            mem_we    = 1'b1;
                            mem_waddr = cpu_addr;
                            mem_wdata = cpu_wdata;
                        end else begin
                            cpu_rdata_d = mem_q[cpu_addr];
                        end
                    end
                    if (dbg_win) begin
                        dbg_gnt_d    = 1'b1;
                        dbg_rvalid_d = !dbg_we;
                        last_dbg_d   = 1'b1;
                        if (dbg_we) begin
                            mem_we    = 1'b1;
                            mem_waddr = dbg_addr;
                            mem_wdata = dbg_wdata;
                        end else begin
                            dbg_rdata_d = mem_q[dbg_addr];
                        end
                    end
                end
            end
            default: state_d = ST_INIT;
        endcase

        init_busy_d = (state_d == ST_INIT);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_INIT;
            cnt_q        <= '0;
            init_busy_q  <= 1'b1;
            cpu_gnt_q    <= 1'b0;
            cpu_rvalid_q <= 1'b0;
            cpu_rdata_q  <= '0;
            dbg_gnt_q    <= 1'b0;
            dbg_rvalid_q <= 1'b0;
            dbg_rdata_q  <= '0;
            conflict_q   <= '0;
            last_dbg_q   <= 1'b1;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            init_busy_q  <= init_busy_d;
            cpu_gnt_q    <= cpu_gnt_d;
            cpu_rvalid_q <= cpu_rvalid_d;
            cpu_rdata_q  <= cpu_rdata_d;
            dbg_gnt_q    <= dbg_gnt_d;
            dbg_rvalid_q <= dbg_rvalid_d;
            dbg_rdata_q  <= dbg_rdata_d;
            conflict_q   <= conflict_d;
            last_dbg_q   <= last_dbg_d;
        end
    end

    always_ff @(posedge clock) begin
        if (mem_we) mem_q[mem_waddr] <= mem_wdata;
    end

    assign cpu_gnt        = cpu_gnt_q;
    assign cpu_rvalid     = cpu_rvalid_q;
    assign cpu_rdata      = cpu_rdata_q;
    assign dbg_gnt        = dbg_gnt_q;
    assign dbg_rvalid     = dbg_rvalid_q;
    assign dbg_rdata      = dbg_rdata_q;
    assign init_busy      = init_busy_q;
    assign conflict_count = conflict_q;

endmodule

// File: tb/tb_data_memory_arbiter.sv
// Directed bench for data_memory_arbiter: init walk, single-port accesses,
// contention, soft re-initialisation and asynchronous reset.
module tb_data_memory_arbiter;
    localparam int AW = 5;
    localparam int DW = 8;

    logic          clock = 1'b0;
    logic          reset, soft_init;
    logic          cpu_req, cpu_we, dbg_req, dbg_we;
    logic [AW-1:0] cpu_addr, dbg_addr;
    logic [DW-1:0] cpu_wdata, dbg_wdata;
    logic          cpu_gnt, cpu_rvalid, dbg_gnt, dbg_rvalid, init_busy;
    logic [DW-1:0] cpu_rdata, dbg_rdata;
    logic [7:0]    conflict_count;

    typedef struct {
        bit            cpu;
        bit            rd;
        logic [DW-1:0] data;
    } exp_t;
    exp_t sb[$];

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    data_memory_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(32)) dut (
        .clock(clock), .reset(reset), .soft_init(soft_init),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
        .init_busy(init_busy), .conflict_count(conflict_count)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Count cycles with init_busy high, starting at the current negedge.
    task automatic count_busy(input string tag, input bit is_cpu);
        int n;
        int ng;
        n  = 0;
        ng = 0;
        while (init_busy === 1'b1 && n < 100) begin
            n++;
            @(negedge clock);
            if ((is_cpu ? cpu_gnt : dbg_gnt) === 1'b1) ng++;
        end
        check({tag, "_busy_len"}, n, 32);
        check({tag, "_no_gnt_in_init"}, ng, 0);
    endtask

    task automatic access(input string tag, input bit is_cpu, input bit we,
                          input logic [AW-1:0] addr, input logic [DW-1:0] wd,
                          input logic [DW-1:0] exp_rd);
        exp_t e;
        int   lat;
        e.cpu  = is_cpu;
        e.rd   = !we;
        e.data = exp_rd;
        sb.push_back(e);
        @(negedge clock);
        if (is_cpu) begin
            cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wd;
        end else begin
            dbg_req = 1'b1; dbg_we = we; dbg_addr = addr; dbg_wdata = wd;
        end
        lat = 0;
        do begin
            @(negedge clock);
            lat++;
        end while ((is_cpu ? cpu_gnt : dbg_gnt) !== 1'b1 && lat < 64);
        cpu_req = 1'b0;
        dbg_req = 1'b0;
        e = sb.pop_front();
        check({tag, "_latency"}, lat, 1);
        check({tag, "_rvalid"}, e.cpu ? cpu_rvalid : dbg_rvalid, e.rd);
        if (e.rd) check({tag, "_rdata"}, e.cpu ? cpu_rdata : dbg_rdata, e.data);
        @(negedge clock);
        check({tag, "_gnt_width"}, is_cpu ? cpu_gnt : dbg_gnt, 0);
    endtask

    initial begin
        exp_t e;
        reset = 1'b1; soft_init = 1'b0;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = '0; dbg_wdata = '0;
        #1 reset = 1'b0;
        repeat (3) @(negedge clock);
        check("rst_init_busy", init_busy, 1);
        check("rst_cpu_gnt", cpu_gnt, 0);
        check("rst_dbg_gnt", dbg_gnt, 0);
        check("rst_cpu_rvalid", cpu_rvalid, 0);
        check("rst_dbg_rvalid", dbg_rvalid, 0);
        check("rst_cpu_rdata", cpu_rdata, 0);
        check("rst_dbg_rdata", dbg_rdata, 0);
        check("rst_conflict", conflict_count, 0);

        // Release reset with a CPU read already held; it must wait for RUN.
        reset = 1'b1;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 5'd9;
        e.cpu = 1'b1; e.rd = 1'b1; e.data = 8'h09;
        sb.push_back(e);
        count_busy("init0", 1'b1);
        check("held_gnt_before", cpu_gnt, 0);
        @(negedge clock);
        cpu_req = 1'b0;
        e = sb.pop_front();
        check("held_gnt", cpu_gnt, 1);
        check("held_rvalid", cpu_rvalid, e.rd);
        check("held_rdata", cpu_rdata, e.data);
        @(negedge clock);
        check("held_single_gnt", cpu_gnt, 0);

        access("cpu_wr3", 1'b1, 1'b1, 5'd3, 8'hA5, 8'h00);
        check("cpu_rdata_hold_wr", cpu_rdata, 8'h09);
        access("cpu_rd3", 1'b1, 1'b0, 5'd3, 8'h00, 8'hA5);
        repeat (3) @(negedge clock);
        check("cpu_rdata_hold", cpu_rdata, 8'hA5);

        access("dbg_rd5", 1'b0, 1'b0, 5'd5, 8'h00, 8'h05);
        access("dbg_rd16", 1'b0, 1'b0, 5'd16, 8'h00, 8'h00);
        access("dbg_rd17", 1'b0, 1'b0, 5'd17, 8'h00, 8'hFF);
        access("dbg_rd31", 1'b0, 1'b0, 5'd31, 8'h00, 8'hF1);

        // Both held; DBG won last, so CPU takes the first contended edge.
        @(negedge clock);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 5'd3;
        dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 5'd17;
        for (int i = 0; i < 8; i++) begin
            @(negedge clock);
            check($sformatf("cont_cpu_gnt%0d", i), cpu_gnt, (i % 2 == 0));
            check($sformatf("cont_dbg_gnt%0d", i), dbg_gnt, (i % 2 == 1));
            check($sformatf("cont_conflict%0d", i), conflict_count, 1);
            if (i % 2 == 0) check($sformatf("cont_cpu_rdata%0d", i), cpu_rdata, 8'hA5);
            else            check($sformatf("cont_dbg_rdata%0d", i), dbg_rdata, 8'hFF);
        end
        cpu_req = 1'b0;
        dbg_req = 1'b0;
        @(negedge clock);

        access("cpu_wr0", 1'b1, 1'b1, 5'd0, 8'h77, 8'h00);
        access("cpu_rd0", 1'b1, 1'b0, 5'd0, 8'h00, 8'h77);

        // soft_init with a DBG read arriving on the same edge.
        @(negedge clock);
        soft_init = 1'b1;
        dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 5'd20;
        e.cpu = 1'b0; e.rd = 1'b1; e.data = 8'hFC;
        sb.push_back(e);
        @(negedge clock);
        soft_init = 1'b0;
        check("soft_no_gnt", dbg_gnt, 0);
        count_busy("soft", 1'b0);
        @(negedge clock);
        dbg_req = 1'b0;
        e = sb.pop_front();
        check("soft_held_gnt", dbg_gnt, 1);
        check("soft_held_rdata", dbg_rdata, e.data);
        access("soft_rd0", 1'b1, 1'b0, 5'd0, 8'h00, 8'h00);
        check("soft_conflict_kept", conflict_count, 1);

        // Asynchronous reset while a CPU grant is showing.
        @(negedge clock);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 5'd3;
        @(posedge clock);
        #2;
        cpu_req = 1'b0;
        check("ar_gnt_pre", cpu_gnt, 1);
        check("ar_rdata_pre", cpu_rdata, 8'h03);
        reset = 1'b0;
        #1;
        check("ar_gnt", cpu_gnt, 0);
        check("ar_rvalid", cpu_rvalid, 0);
        check("ar_rdata", cpu_rdata, 0);
        check("ar_busy", init_busy, 1);
        check("ar_conflict", conflict_count, 0);
        @(negedge clock);
        reset = 1'b1;
        count_busy("ar_init", 1'b1);
        access("ar_rd3", 1'b0, 1'b0, 5'd3, 8'h00, 8'h03);
        check("sb_empty", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
